tdm_slot_mux: RTL and testbench
===============================

# tdm_slot_mux

Fixed-slot time-division multiplexer for the transmit side of the demux-based channel path. It merges NUM_CH independent valid/ready input channels onto one registered output stream. Every slot carries exactly one beat, either real data or a filler beat, so the receiving demultiplexer recovers channels purely by position plus a start-of-frame marker. It sits between the per-channel producers and the shared link that feeds the demux.

## Interface
- NUM_CH, 4: number of input channels; 2..16.
- DATA_W, 8: data width per channel.
- SEL_W, $clog2(NUM_CH): width of the slot index.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  slot engine enable; when low no new beat is loaded.
- in_valid  input  NUM_CH  per-channel valid; bit k is channel k.
- in_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel ready; combinational, at most one bit high.
- out_valid  output  1  output beat present.
- out_data  output  DATA_W  beat payload; 0 for filler.
- out_sel  output  SEL_W  slot index of the beat.
- out_fill  output  1  beat is filler (no channel data).
- out_sof  output  1  beat is slot 0 (start of frame).
- out_ready  input  1  downstream accepts beat.
- frame_cnt  output  8  count of completed frames; wraps 255->0.

## Operation
- Single output register holds {out_data, out_sel, out_fill, out_sof}; out_valid is its occupancy flag.
- load = en && (!out_valid || out_ready).
- Slot counter `slot` runs 0..NUM_CH-1 and advances only on load. It wraps NUM_CH-1 -> 0.
- On load:
  - If in_valid[slot], capture in_data of channel `slot` with out_fill=0.
  - Otherwise capture 0 with out_fill=1.
  - out_sel=slot, out_sof=(slot==0), out_valid=1.
- in_ready[k] = load && (slot==k). A channel handshake occurs only when in_valid[k] and in_ready[k] are both high.
- No load while out_valid && !out_ready: the register and all outputs hold stable and slot does not advance (backpressure).
- If en is low and out_ready is high, out_valid clears to 0 after the held beat drains. The slot position is kept, so re-enabling resumes mid-frame.
- frame_cnt increments on a load where slot==NUM_CH-1.
- The block never skips a slot and never reorders. Filler is emitted rather than waiting for a channel.

## Timing
- Reset (rst_n low at a clk edge) gives:
  - out_valid=0, out_data=0, out_sel=0, out_fill=0, out_sof=0.
  - slot=0, frame_cnt=0.
  - in_ready=0 during reset.
- Latency is 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
- Full throughput with en=1 and out_ready=1 is one beat per cycle. A frame is NUM_CH cycles.
- A simultaneous drain and load in the same cycle (out_valid && out_ready && en) replaces the register with no bubble.
- Reset asserted mid-frame discards the held beat. The first beat after reset is slot 0 with out_sof=1.
- in_ready depends combinationally on out_ready and en. There is no combinational path from in_valid to in_ready.

## Structure
- A shared package tdm_pkg holds:
  - the default NUM_CH and DATA_W constants;
  - the fill word constant (0);
  - the frame_cnt width (8).
  The matching demux receiver uses the same package.
- One sub-module is natural: tdm_slot_ctr. It is the modulo-NUM_CH counter with an advance input and outputs slot and wrap. Output register and data muxing stay in the top.

## Test plan
- Reset: drive rst_n=0 with all in_valid=1 for 2 cycles -> all outputs 0, in_ready=0000. Release rst_n with out_ready=1 and en=1 -> the first beat has out_sel=0, out_sof=1.
- Full traffic: NUM_CH=4, all valid, channel k data=8'hA0+k, out_ready=1 -> out_data A0,A1,A2,A3,A0... with out_fill=0. frame_cnt=2 after 8 beats.
- Filler: only channel 2 valid with 8'h5C -> per frame the beats are sel 0,1,3 with out_fill=1, out_data=0, and sel 2 carries 8'h5C with out_fill=0.
- Backpressure: drop out_ready for 3 cycles while beat sel=1 is held -> out_* stable, in_ready=0000, slot unchanged. Reassert out_ready -> the next beat is sel=2 with no loss or duplication.
- Enable gating: drop en after beat sel=2 with out_ready=1 -> out_valid=0 after drain. Re-raise en -> the next beat is sel=3, then sel=0 with out_sof=1.
- frame_cnt wrap: run 256 full frames -> frame_cnt returns to 0. Then assert reset mid-frame -> the next beat is sel=0 and frame_cnt=0.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: constants shared by the TDM slot multiplexer and its matching demux receiver.
// Holds the default channel count and data width, the filler word and the frame counter width.
package tdm_pkg;
    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int FRAME_W = 8;
    localparam logic [63:0] FILL_WORD = '0;
endpackage

// File: rtl/tdm_slot_mux_if.sv
// tdm_slot_mux_if: channel-side and link-side beat signals of the TDM slot multiplexer.
// Ports: in_valid/in_data/in_ready per channel; out_valid/out_data/out_sel/out_fill/out_sof/out_ready on the link.
// Modports: master = producers plus downstream sink (testbench side); slave = the multiplexer.
interface tdm_slot_mux_if
    import tdm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int SEL_W = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0] in_ready;
    logic out_valid;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0] out_sel;
    logic out_fill;
    logic out_sof;
    logic out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input in_ready, out_valid, out_data, out_sel, out_fill, out_sof
    );

    modport slave (
        input in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_fill, out_sof
    );
endinterface

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: modulo-N slot counter advancing on adv.
// Ports: clk, rst_n (sync, active-low), adv (advance), slot (current slot), wrap (slot is the last one, N-1).
module tdm_slot_ctr #(
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [SEL_W-1:0] slot,
    output logic             wrap
);
    assign wrap = slot == SEL_W'(N - 1);

    always_ff @(posedge clk) begin
        if (!rst_n)
            slot <= '0;
        else if (adv)
            slot <= wrap ? '0 : slot + 1'b1;
    end
endmodule

// File: rtl/tdm_slot_mux.sv
// tdm_slot_mux: fixed-slot TDM multiplexer; one beat per slot, filler when the slot's channel is idle.
// Ports: clk, rst_n (sync, active-low), en (slot engine enable), bus (channel and link signals),
// frame_cnt (completed frames, wraps 255->0).
module tdm_slot_mux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    tdm_slot_mux_if.slave      bus,
    output logic [FRAME_W-1:0] frame_cnt
);
    logic load;
    logic wrap;
    logic hit;
    logic [SEL_W-1:0] slot;
    logic [DATA_W-1:0] ch_data;

    // Gating with rst_n keeps in_ready low while reset is held.
    assign load = rst_n && en && (!bus.out_valid || bus.out_ready);
    assign hit = bus.in_valid[slot];
    assign ch_data = bus.in_data[slot*DATA_W +: DATA_W];

    tdm_slot_ctr #(.N(NUM_CH)) u_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .adv  (load),
        .slot (slot),
        .wrap (wrap)
    );

    always_comb begin
        bus.in_ready = '0;
        bus.in_ready[slot] = load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_sel <= '0;
            bus.out_fill <= 1'b0;
            bus.out_sof <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (load) begin
                bus.out_valid <= 1'b1;
                bus.out_data <= hit ? ch_data : FILL_WORD[DATA_W-1:0];
                bus.out_sel <= slot;
                bus.out_fill <= !hit;
                bus.out_sof <= slot == '0;
            end else if (bus.out_ready) begin
                // Held beat drains while disabled; slot position is retained.
                bus.out_valid <= 1'b0;
            end
            if (load && wrap)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tdm_slot_mux.sv
// tb_tdm_slot_mux: directed and randomized checks of tdm_slot_mux against a behavioural slot model.
module tb_tdm_slot_mux;
    localparam int NC = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [7:0] frame_cnt;
    int total = 0;
    int bad = 0;

    int m_slot = 0;
    int m_frames = 0;
    bit m_valid = 0;
    int m_data = 0;
    int m_sel = 0;
    bit m_fill = 0;
    bit m_sof = 0;

    tdm_slot_mux_if #(.NUM_CH(NC), .DATA_W(DW)) bus ();

    tdm_slot_mux #(.NUM_CH(NC), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bus      (bus),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ch_byte(int k);
        logic [31:0] d;
        d = bus.in_data;
        return int'(d[k*8 +: 8]);
    endfunction

    // One clock: check in_ready before the edge, advance the model, check outputs after the edge.
    task automatic tick();
        bit ld;
        #1;
        ld = rst_n && en && (!m_valid || bus.out_ready);
        chk("in_ready", 32'(bus.in_ready), ld ? 32'(1 << m_slot) : 32'd0);
        @(posedge clk);
        if (!rst_n) begin
            m_slot = 0; m_frames = 0; m_valid = 0; m_data = 0; m_sel = 0; m_fill = 0; m_sof = 0;
        end else if (ld) begin
            m_valid = 1;
            m_fill = !bus.in_valid[m_slot];
            m_data = m_fill ? 0 : ch_byte(m_slot);
            m_sel = m_slot;
            m_sof = m_slot == 0;
            if (m_slot == NC - 1) m_frames = (m_frames + 1) % 256;
            m_slot = (m_slot + 1) % NC;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_sel", 32'(bus.out_sel), 32'(m_sel));
        chk("out_fill", 32'(bus.out_fill), 32'(m_fill));
        chk("out_sof", 32'(bus.out_sof), 32'(m_sof));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    endtask

    task automatic drive(input bit r, input bit e, input bit rdy, input logic [3:0] v, input logic [31:0] d);
        rst_n = r;
        en = e;
        bus.out_ready = rdy;
        bus.in_valid = v;
        bus.in_data = d;
        tick();
    endtask

    initial begin
        logic [31:0] pat;
        bit found;
        pat = 32'hA3A2A1A0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;

        drive(0, 1, 1, 4'hF, pat);
        drive(0, 1, 1, 4'hF, pat);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ready", 32'(bus.in_ready), 0);
        drive(1, 1, 1, 4'hF, pat);
        chk("first_sel", 32'(bus.out_sel), 0);
        chk("first_sof", 32'(bus.out_sof), 1);

        drive(0, 1, 1, 4'hF, pat);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 4'hF, pat);
            chk("full_data", 32'(bus.out_data), 32'(8'hA0 + i % 4));
            chk("full_fill", 32'(bus.out_fill), 0);
        end
        chk("full_frames", 32'(frame_cnt), 2);

        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 4'b0100, 32'h005C0000);
            chk("fill_data", 32'(bus.out_data), (i == 2) ? 32'h5C : 32'h0);
            chk("fill_flag", 32'(bus.out_fill), (i == 2) ? 32'h0 : 32'h1);
        end

        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            drive(1, 1, 1, 4'hF, pat);
            found = bus.out_valid && bus.out_sel == 1;
        end
        chk("bp_reach_sel1", 32'(found), 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 4'hF, pat);
            chk("bp_hold_sel", 32'(bus.out_sel), 1);
            chk("bp_hold_data", 32'(bus.out_data), 32'hA1);
        end
        drive(1, 1, 1, 4'hF, pat);
        chk("bp_next_sel", 32'(bus.out_sel), 2);
        chk("bp_next_data", 32'(bus.out_data), 32'hA2);

        drive(1, 0, 1, 4'hF, pat);
        chk("en_drain", 32'(bus.out_valid), 0);
        drive(1, 0, 1, 4'hF, pat);
        drive(1, 1, 1, 4'hF, pat);
        chk("en_resume_sel", 32'(bus.out_sel), 3);
        drive(1, 1, 1, 4'hF, pat);
        chk("en_wrap_sel", 32'(bus.out_sel), 0);
        chk("en_wrap_sof", 32'(bus.out_sof), 1);

        for (int i = 0; i < 2000; i++)
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  4'($urandom), $urandom);

        drive(0, 1, 1, 4'hF, pat);
        for (int i = 0; i < 256 * NC; i++)
            drive(1, 1, 1, 4'($urandom), $urandom);
        chk("wrap_frames", 32'(frame_cnt), 0);
        drive(1, 1, 1, 4'hF, pat);
        drive(1, 1, 1, 4'hF, pat);
        drive(0, 1, 1, 4'hF, pat);
        drive(1, 1, 1, 4'hF, pat);
        chk("post_rst_sel", 32'(bus.out_sel), 0);
        chk("post_rst_frames", 32'(frame_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
